// File: rtl/fx_pkg.sv
// fx_pkg: Q16.16 fixed-point definitions shared by the divider and the multiplier.
//   - format constants (width, fraction bits, one, saturation limits)
//   - divider FSM state encoding
//   - fx_saturate(): clamps a sign + wide magnitude into a Q16.16 word
package fx_pkg;

  localparam int FX_WIDTH = 32;
  localparam int FX_FRAC  = 16;
  localparam int FX_QW    = FX_WIDTH + FX_FRAC;

  localparam logic [FX_WIDTH-1:0] FX_ONE = 32'h0001_0000;
  localparam logic [FX_WIDTH-1:0] FX_MAX = 32'h7FFF_FFFF;
  localparam logic [FX_WIDTH-1:0] FX_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    FX_IDLE   = 2'd0,
    FX_CALC   = 2'd1,
    FX_FINISH = 2'd2
  } fx_div_state_e;

  // Magnitudes up to 2^31 fit a negative result; anything larger clamps.
  // A zero magnitude yields 0 for either sign (no negative zero).
  function automatic logic [FX_WIDTH-1:0] fx_saturate(input logic neg_i,
                                                      input logic [FX_QW-1:0] mag_i);
    logic [FX_WIDTH-1:0] res;
    if (!neg_i) begin
      if (mag_i > {{(FX_QW-FX_WIDTH){1'b0}}, FX_MAX}) begin
        res = FX_MAX;
      end else begin
        res = mag_i[FX_WIDTH-1:0];
      end
    end else begin
      if (mag_i > {{(FX_QW-FX_WIDTH){1'b0}}, FX_MIN}) begin
        res = FX_MIN;
      end else begin
        res = {FX_WIDTH{1'b0}} - mag_i[FX_WIDTH-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fx_div_step.sv
// fx_div_step: one restoring-division step (combinational).
//   rem_i  : partial remainder, always < div_i
//   bit_i  : next dividend bit shifted into the remainder
//   div_i  : divisor magnitude
//   rem_o  : updated remainder
//   q_o    : quotient bit produced by this step
module fx_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted_s;

  // Shift-in, compare, conditionally subtract. After a subtract the
  // remainder is below div_i, so it always fits back into WIDTH bits.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    if (shifted_s >= {1'b0, div_i}) begin
      q_o   = 1'b1;
      rem_o = shifted_s[WIDTH-1:0] - div_i;
    end else begin
      q_o   = 1'b0;
      rem_o = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fx_divider.sv
// fx_divider: sequential signed Q16.16 divider, result = x / y, saturated.
// Restoring long division, one quotient bit per clock, fixed latency.
//   clk, rst (sync, active-high)   start: request, sampled in IDLE only
//   x, y   : dividend / divisor, captured on accept
//   busy   : accept edge until done      done: one-cycle result-valid pulse
//   result : saturated quotient, held    div_by_zero: held with result
// Optional macro FX_DIVIDER_ROUND_EN: one extra guard step and
// round-half-away-from-zero on the magnitude (latency 50 instead of 49).
module fx_divider
  import fx_pkg::*;
#(
  parameter int WIDTH     = FX_WIDTH,
  parameter int FRAC_BITS = FX_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int QW = WIDTH + FRAC_BITS;
`ifdef FX_DIVIDER_ROUND_EN
  localparam int ITERS = QW + 1;
`else
  localparam int ITERS = QW;
`endif
  localparam int IW = $clog2(ITERS + 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

  fx_div_state_e    state_q;
  logic             neg_q;
  logic             xneg_q;
  logic             yzero_q;
  logic [WIDTH-1:0] ymag_q;
  logic [ITERS-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [ITERS-1:0] quo_q;
  logic [IW-1:0]    iter_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic [WIDTH-1:0] xmag_s;
  logic [WIDTH-1:0] ymag_s;
  logic [WIDTH-1:0] rem_d;
  logic             q_bit_s;
  logic [QW-1:0]    qmag_s;
  logic [WIDTH-1:0] fin_result_d;
  logic             fin_dbz_d;

  // Operand magnitudes; |0x80000000| = 2^31 is exact as an unsigned value.
  always_comb begin
    xmag_s = x[WIDTH-1] ? ({WIDTH{1'b0}} - x) : x;
    ymag_s = y[WIDTH-1] ? ({WIDTH{1'b0}} - y) : y;
  end

  fx_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[ITERS-1]),
    .div_i (ymag_q),
    .rem_o (rem_d),
    .q_o   (q_bit_s)
  );

  // Final magnitude (optionally rounded via the guard bit), then sign/saturate.
  always_comb begin
`ifdef FX_DIVIDER_ROUND_EN
    qmag_s = quo_q[ITERS-1:1] + QW'(quo_q[0]);
`else
    qmag_s = quo_q;
`endif
    if (yzero_q) begin
      fin_dbz_d    = 1'b1;
      fin_result_d = xneg_q ? FX_MIN : FX_MAX;
    end else begin
      fin_dbz_d    = 1'b0;
      fin_result_d = fx_saturate(neg_q, qmag_s);
    end
  end

  // Control FSM and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FX_IDLE;
      neg_q    <= 1'b0;
      xneg_q   <= 1'b0;
      yzero_q  <= 1'b0;
      ymag_q   <= {WIDTH{1'b0}};
      dvd_q    <= {ITERS{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {ITERS{1'b0}};
      iter_q   <= {IW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        FX_IDLE: begin
          if (start) begin
            neg_q   <= x[WIDTH-1] ^ y[WIDTH-1];
            xneg_q  <= x[WIDTH-1];
            yzero_q <= (y == {WIDTH{1'b0}});
            ymag_q  <= ymag_s;
            // Left-align |x| so the quotient carries the fractional bits.
            dvd_q   <= {xmag_s, {(ITERS-WIDTH){1'b0}}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {ITERS{1'b0}};
            iter_q  <= {IW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= FX_CALC;
          end else begin
            state_q <= FX_IDLE;
          end
        end
        FX_CALC: begin
          rem_q  <= rem_d;
          quo_q  <= {quo_q[ITERS-2:0], q_bit_s};
          dvd_q  <= {dvd_q[ITERS-2:0], 1'b0};
          iter_q <= iter_q + IW'(1);
          if (iter_q == LAST_ITER) begin
            state_q <= FX_FINISH;
          end else begin
            state_q <= FX_CALC;
          end
        end
        FX_FINISH: begin
          result_q <= fin_result_d;
          dbz_q    <= fin_dbz_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= FX_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= FX_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fx_divider.sv
// tb_fx_divider: directed and randomized checks of fx_divider against an
// arithmetic reference model (64-bit integer division + saturation rules).
// Honours FX_DIVIDER_ROUND_EN for the expected latency and rounding.
module tb_fx_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

`ifdef FX_DIVIDER_ROUND_EN
  localparam int LAT   = 50;
  localparam bit ROUND = 1'b1;
`else
  localparam int LAT   = 49;
  localparam bit ROUND = 1'b0;
`endif

  always #5 clk = ~clk;

  fx_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, result} computed from the arithmetic definition.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ax, ay, q, r;
    bit neg;
    logic [31:0] res;
    if (b == 32'd0) return {1'b1, (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ax = (sa < 0) ? -sa : sa;
    ay = (sb < 0) ? -sb : sb;
    neg = a[31] ^ b[31];
    if (ROUND) begin
      q = (ax << 17) / ay;
      q = (q >> 1) + (q & 64'd1);
    end else begin
      q = (ax << 16) / ay;
    end
    if (!neg) begin
      res = (q > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : q[31:0];
    end else if (q > 64'h8000_0000) begin
      res = 32'h8000_0000;
    end else begin
      r   = -q;
      res = r[31:0];
    end
    return {1'b0, res};
  endfunction

  // mode 0: plain; mode 1: stray start at edge k+10; mode 2: reset at edge k+20.
  task automatic run(input logic [31:0] xa, input logic [31:0] ya, input int mode,
                     input string tag);
    logic [32:0] e;
    int n;
    bit seen;
    bit busy_ok;
    e = ref_div(xa, ya);
    @(negedge clk);
    x = xa; y = ya; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_acc"}, busy, 1);
    seen = 1'b0;
    busy_ok = 1'b1;
    for (n = 1; n <= LAT + 5; n++) begin
      @(negedge clk);
      start = (mode == 1 && n == 10);
      if (mode == 1 && n == 10) begin
        x = ~xa; y = 32'h0001_0000;
      end
      rst = (mode == 2 && n == 20);
      @(posedge clk); #1;
      if (mode == 2 && n == 20) begin
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_result"}, result, 0);
        check({tag, "_rst_dbz"}, div_by_zero, 0);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy && !(mode == 2 && n >= 20)) busy_ok = 1'b0;
    end
    start = 1'b0;
    rst = 1'b0;
    if (mode == 2) begin
      check({tag, "_no_done"}, seen, 0);
    end else begin
      check({tag, "_latency"}, n, LAT);
      check({tag, "_busy_run"}, busy_ok, 1);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_result"}, result, e[31:0]);
      check({tag, "_dbz"}, div_by_zero, e[32]);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_held"}, result, e[31:0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    rst = 1'b1; start = 1'b0; x = 32'd0; y = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    run(32'h0006_0000, 32'h0002_0000, 0, "six_by_two");
    run(32'h0002_0000, 32'h0003_0000, 0, "two_thirds");
    check("two_thirds_val", result, ROUND ? 32'h0000_AAAB : 32'h0000_AAAA);
    run(32'hFFF8_8000, 32'h0002_8000, 0, "neg_7p5");
    check("neg_7p5_val", result, 32'hFFFD_0000);
    run(32'h7FFF_0000, 32'h0000_0001, 0, "sat_pos");
    check("sat_pos_val", result, 32'h7FFF_FFFF);
    run(32'h8000_0000, 32'h0000_8000, 0, "sat_neg");
    check("sat_neg_val", result, 32'h8000_0000);
    run(32'hFFFF_0000, 32'h0000_0000, 0, "dz_neg");
    check("dz_neg_val", {div_by_zero, result}, {1'b1, 32'h8000_0000});
    run(32'h0000_0000, 32'h0000_0000, 0, "dz_zero");
    check("dz_zero_val", {div_by_zero, result}, {1'b1, 32'h7FFF_FFFF});
    run(32'h0006_0000, 32'h0002_0000, 0, "dz_clear");
    check("dz_clear_val", {div_by_zero, result}, {1'b0, 32'h0003_0000});
    run(32'h0000_0000, 32'hFFFE_0000, 0, "zero_neg");
    run(32'h8000_0000, 32'hFFFF_FFFF, 0, "min_by_neg");
    run(32'h0004_0000, 32'h0001_0000, 1, "stray_start");
    check("stray_start_val", result, 32'h0004_0000);
    run(32'h0009_0000, 32'h0003_0000, 2, "abort");
    run(32'h0009_0000, 32'h0003_0000, 0, "after_abort");
    check("after_abort_val", result, 32'h0003_0000);

    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = $urandom_range(0, 255);
        2: ry = ($urandom & 32'h000F_FFFF) ^ ({32{rx[0]}});
        default: ry = $urandom_range(0, 2);
      endcase
      run(rx, ry, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
